// File: rtl/br_stats_pkg.sv
// Shared types and helpers for the branch-statistics monitor.
// Optional mispredict-PC trace is enabled with `define BR_STATS_TRACE_EN.
package br_stats_pkg;

    // Widest counter supported; snapshot fields and the increment helper use it.
    localparam int unsigned SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } br_state_e;

    typedef struct packed {
        logic [SAT_W-1:0] cyc;
        logic [SAT_W-1:0] insn;
        logic [SAT_W-1:0] br;
        logic [SAT_W-1:0] miss;
    } snap_t;

    // Returns {attempted-at-max, next value}; the value holds at 2^w-1.
    function automatic logic [SAT_W:0] sat_inc(
        input logic [SAT_W-1:0] val,
        input logic             en,
        input int unsigned      w
    );
        logic [SAT_W-1:0] max_val;
        max_val = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        if (!en) begin
            return {1'b0, val};
        end else if (val == max_val) begin
            return {1'b1, val};
        end else begin
            return {1'b0, val + SAT_W'(1)};
        end
    endfunction

endpackage

// File: rtl/br_stats_monitor_if.sv
// Control, event and snapshot signals of br_stats_monitor.
// Trace signals are always present; they only carry data with BR_STATS_TRACE_EN.
interface br_stats_monitor_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start_i;
    logic             stop_i;
    logic             clr_i;
    logic             br_instr_i;
    logic             br_miss_i;
    logic [31:0]      pc_i;
    logic             insn_vld_i;
    logic             snap_req_i;
    logic             snap_vld_o;
    logic [CNT_W-1:0] cyc_cnt_o;
    logic [CNT_W-1:0] insn_cnt_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] miss_cnt_o;
    logic             run_o;
    logic             ovf_o;
    logic             trc_pop_i;
    logic             trc_vld_o;
    logic [31:0]      trc_pc_o;
    logic             trc_drop_o;

    modport master (
        output start_i, stop_i, clr_i, br_instr_i, br_miss_i, pc_i,
               insn_vld_i, snap_req_i, trc_pop_i,
        input  snap_vld_o, cyc_cnt_o, insn_cnt_o, br_cnt_o, miss_cnt_o,
               run_o, ovf_o, trc_vld_o, trc_pc_o, trc_drop_o
    );

    modport slave (
        input  start_i, stop_i, clr_i, br_instr_i, br_miss_i, pc_i,
               insn_vld_i, snap_req_i, trc_pop_i,
        output snap_vld_o, cyc_cnt_o, insn_cnt_o, br_cnt_o, miss_cnt_o,
               run_o, ovf_o, trc_vld_o, trc_pc_o, trc_drop_o
    );

endinterface

// File: rtl/br_stats_trace_fifo.sv
// First-word-fall-through FIFO of mispredicting PCs with a sticky drop flag.
// Only instantiated when BR_STATS_TRACE_EN is defined.
module br_stats_trace_fifo #(
    parameter int unsigned TRC_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [31:0] pc_i,
    input  logic        pop_i,
    output logic        vld_o,
    output logic [31:0] pc_o,
    output logic        drop_o
);

    localparam int unsigned AW = $clog2(TRC_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(TRC_DEPTH);

    logic [31:0]   mem [TRC_DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          drop_q;
    logic          empty;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign pop_ok  = pop_i & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_ok = push_i & (~full | pop_ok);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else if (clr_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (push_i && !push_ok) drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) mem[wr_q] <= pc_i;
    end

    assign vld_o  = ~empty;
    assign pc_o   = empty ? '0 : mem[rd_q];
    assign drop_o = drop_q;

endmodule

// File: rtl/br_stats_monitor.sv
// Branch-statistics monitor: run/hold FSM, saturating live counters, snapshot handshake.
// Define BR_STATS_TRACE_EN to add the mispredict-PC trace FIFO.
module br_stats_monitor
    import br_stats_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TRC_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    br_stats_monitor_if.slave mon
);

    br_state_e        state_q;
    br_state_e        state_d;
    logic             run;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] insn_q;
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] miss_q;
    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] insn_inc;
    logic [CNT_W-1:0] br_inc;
    logic [CNT_W-1:0] miss_inc;
    logic [SAT_W:0]   cyc_r;
    logic [SAT_W:0]   insn_r;
    logic [SAT_W:0]   br_r;
    logic [SAT_W:0]   miss_r;
    logic             ovf_evt;
    logic             ovf_q;
    logic             miss_evt;
    logic             snap_vld_q;
    snap_t            snap_q;
    logic             trc_vld;
    logic [31:0]      trc_pc;
    logic             trc_drop;
    logic             unused_bits;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // stop_i dominates start_i in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mon.start_i && !mon.stop_i) state_d = RUN;
            RUN:     if (mon.stop_i) state_d = HOLD;
            HOLD:    if (mon.start_i && !mon.stop_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    assign run      = (state_q == RUN);
    assign miss_evt = run & mon.br_instr_i & mon.br_miss_i;

    always_comb begin
        cyc_r    = sat_inc(SAT_W'(cyc_q), run, CNT_W);
        insn_r   = sat_inc(SAT_W'(insn_q), run & mon.insn_vld_i, CNT_W);
        br_r     = sat_inc(SAT_W'(br_q), run & mon.br_instr_i, CNT_W);
        miss_r   = sat_inc(SAT_W'(miss_q), miss_evt, CNT_W);
        cyc_inc  = cyc_r[CNT_W-1:0];
        insn_inc = insn_r[CNT_W-1:0];
        br_inc   = br_r[CNT_W-1:0];
        miss_inc = miss_r[CNT_W-1:0];
        ovf_evt  = cyc_r[SAT_W] | insn_r[SAT_W] | br_r[SAT_W] | miss_r[SAT_W];
    end

    // The snapshot takes the incremented values before clr_i is applied,
    // so a same-cycle request sees that cycle's events and the pre-clear totals.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q      <= '0;
            insn_q     <= '0;
            br_q       <= '0;
            miss_q     <= '0;
            ovf_q      <= 1'b0;
            snap_vld_q <= 1'b0;
            snap_q     <= '0;
        end else begin
            if (mon.clr_i) begin
                cyc_q  <= '0;
                insn_q <= '0;
                br_q   <= '0;
                miss_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                cyc_q  <= cyc_inc;
                insn_q <= insn_inc;
                br_q   <= br_inc;
                miss_q <= miss_inc;
                if (ovf_evt) ovf_q <= 1'b1;
            end
            snap_vld_q <= mon.snap_req_i;
            if (mon.snap_req_i) begin
                snap_q.cyc  <= SAT_W'(cyc_inc);
                snap_q.insn <= SAT_W'(insn_inc);
                snap_q.br   <= SAT_W'(br_inc);
                snap_q.miss <= SAT_W'(miss_inc);
            end
        end
    end

    assign mon.snap_vld_o = snap_vld_q;
    assign mon.cyc_cnt_o  = snap_q.cyc[CNT_W-1:0];
    assign mon.insn_cnt_o = snap_q.insn[CNT_W-1:0];
    assign mon.br_cnt_o   = snap_q.br[CNT_W-1:0];
    assign mon.miss_cnt_o = snap_q.miss[CNT_W-1:0];
    assign mon.run_o      = run;
    assign mon.ovf_o      = ovf_q;

`ifdef BR_STATS_TRACE_EN
    br_stats_trace_fifo #(
        .TRC_DEPTH(TRC_DEPTH)
    ) u_trace (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (mon.clr_i),
        .push_i (miss_evt),
        .pc_i   (mon.pc_i),
        .pop_i  (mon.trc_pop_i),
        .vld_o  (trc_vld),
        .pc_o   (trc_pc),
        .drop_o (trc_drop)
    );
    assign unused_bits = ^{cyc_r, insn_r, br_r, miss_r, snap_q};
`else
    assign trc_vld     = 1'b0;
    assign trc_pc      = '0;
    assign trc_drop    = 1'b0;
    assign unused_bits = ^{cyc_r, insn_r, br_r, miss_r, snap_q, mon.pc_i, mon.trc_pop_i};
`endif

    assign mon.trc_vld_o  = trc_vld;
    assign mon.trc_pc_o   = trc_pc;
    assign mon.trc_drop_o = trc_drop;

endmodule

// File: tb/tb_br_stats_monitor.sv
// Directed bench for br_stats_monitor: a 32-bit instance driven from a vector table,
// a 4-bit instance for saturation, and trace checks when BR_STATS_TRACE_EN is defined.
module tb_br_stats_monitor;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    br_stats_monitor_if #(.CNT_W(32)) b32 ();
    br_stats_monitor_if #(.CNT_W(4))  b4 ();

    br_stats_monitor #(.CNT_W(32), .TRC_DEPTH(8)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .mon   (b32)
    );

    br_stats_monitor #(.CNT_W(4), .TRC_DEPTH(8)) u_dut4 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .mon   (b4)
    );

    // ctl = {start, stop, clr, br_instr, br_miss, insn_vld, snap_req}; rv = {run, snap_vld}
    typedef struct {
        logic [6:0]  ctl;
        logic [1:0]  rv;
        bit          chk;
        int unsigned cyc;
        int unsigned ins;
        int unsigned brc;
        int unsigned mis;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] ctl, input logic [1:0] rv, input bit chk,
                                input int unsigned cyc, input int unsigned ins,
                                input int unsigned brc, input int unsigned mis);
        vec_t v;
        v.ctl = ctl; v.rv = rv; v.chk = chk;
        v.cyc = cyc; v.ins = ins; v.brc = brc; v.mis = mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] c);
        {b32.start_i, b32.stop_i, b32.clr_i, b32.br_instr_i,
         b32.br_miss_i, b32.insn_vld_i, b32.snap_req_i} = c;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        rst_i = 1'b1;
        drive(7'b0);
        b32.pc_i = '0; b32.trc_pop_i = 1'b0;
        b4.start_i = 1'b0; b4.stop_i = 1'b0; b4.clr_i = 1'b0; b4.br_instr_i = 1'b0;
        b4.br_miss_i = 1'b0; b4.insn_vld_i = 1'b0; b4.snap_req_i = 1'b0;
        b4.pc_i = '0; b4.trc_pop_i = 1'b0;

        #12;
        check("rst run",      64'(b32.run_o), 64'd0);
        check("rst snap_vld", 64'(b32.snap_vld_o), 64'd0);
        check("rst cyc",      64'(b32.cyc_cnt_o), 64'd0);
        check("rst ovf",      64'(b32.ovf_o), 64'd0);
        check("rst trc_vld",  64'(b32.trc_vld_o), 64'd0);
        check("rst trc_drop", 64'(b32.trc_drop_o), 64'd0);
        check("rst4 cyc",     64'(b4.cyc_cnt_o), 64'd0);
        rst_i = 1'b0;

        vecs.push_back(mk(7'b0000000, 2'b00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'b1000000, 2'b10, 0, 0, 0, 0, 0));
        for (int i = 2; i <= 10; i++) begin
            logic b, m;
            b = (i == 2) || (i == 4) || (i == 6) || (i == 8);
            m = (i == 4);
            vecs.push_back(mk({3'b000, b, m, 2'b10}, 2'b10, 0, 0, 0, 0, 0));
        end
        vecs.push_back(mk(7'b0000011, 2'b11, 1, 10, 10, 4, 1));
        vecs.push_back(mk(7'b0010100, 2'b10, 1, 10, 10, 4, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(7'b0000100, 2'b10, 0, 0, 0, 0, 0));
        vecs.push_back(mk(7'b0000101, 2'b11, 1, 5, 0, 0, 0));
        vecs.push_back(mk(7'b1101110, 2'b00, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(7'b0001110, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(7'b0001111, 2'b01, 1, 6, 1, 1, 1));
        vecs.push_back(mk(7'b1001010, 2'b10, 0, 0, 0, 0, 0));
        vecs.push_back(mk(7'b0001011, 2'b11, 1, 7, 2, 2, 1));
        vecs.push_back(mk(7'b0000001, 2'b11, 1, 8, 2, 2, 1));
        vecs.push_back(mk(7'b0000000, 2'b10, 1, 8, 2, 2, 1));
        vecs.push_back(mk(7'b0010000, 2'b10, 0, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(7'b0001000, 2'b10, 0, 0, 0, 0, 0));
        vecs.push_back(mk(7'b0011001, 2'b11, 1, 8, 0, 8, 0));
        vecs.push_back(mk(7'b0000001, 2'b11, 1, 1, 0, 0, 0));
        vecs.push_back(mk(7'b0100000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(7'b0000001, 2'b01, 1, 2, 0, 0, 0));
        vecs.push_back(mk(7'b1100000, 2'b00, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].ctl);
            tick();
            check($sformatf("v%0d run", i),      64'(b32.run_o), 64'(vecs[i].rv[1]));
            check($sformatf("v%0d snap_vld", i), 64'(b32.snap_vld_o), 64'(vecs[i].rv[0]));
            check($sformatf("v%0d ovf", i),      64'(b32.ovf_o), 64'd0);
            if (vecs[i].chk) begin
                check($sformatf("v%0d cyc", i),  64'(b32.cyc_cnt_o), 64'(vecs[i].cyc));
                check($sformatf("v%0d insn", i), 64'(b32.insn_cnt_o), 64'(vecs[i].ins));
                check($sformatf("v%0d br", i),   64'(b32.br_cnt_o), 64'(vecs[i].brc));
                check($sformatf("v%0d miss", i), 64'(b32.miss_cnt_o), 64'(vecs[i].mis));
            end
        end

        // Asynchronous reset mid-run, with a snapshot request pending.
        drive(7'b1000000); tick();
        check("pre-rst run", 64'(b32.run_o), 64'd1);
        drive(7'b0001111);
        #2 rst_i = 1'b1;
        #1;
        check("async rst run",      64'(b32.run_o), 64'd0);
        check("async rst snap_vld", 64'(b32.snap_vld_o), 64'd0);
        check("async rst cyc",      64'(b32.cyc_cnt_o), 64'd0);
        check("async rst br",       64'(b32.br_cnt_o), 64'd0);
        drive(7'b0);
        #2 rst_i = 1'b0;
        tick();
        check("post-rst snap_vld", 64'(b32.snap_vld_o), 64'd0);
        check("post-rst run",      64'(b32.run_o), 64'd0);
        drive(7'b1100000); tick();
        check("idle start+stop run", 64'(b32.run_o), 64'd0);
        drive(7'b1000000); tick();
        check("idle start run", 64'(b32.run_o), 64'd1);
        drive(7'b0000001); tick();
        check("post-rst snap cyc",  64'(b32.cyc_cnt_o), 64'd1);
        check("post-rst snap insn", 64'(b32.insn_cnt_o), 64'd0);
        drive(7'b0);

`ifdef BR_STATS_TRACE_EN
        for (int i = 0; i < 9; i++) begin
            drive(7'b0001100);
            b32.pc_i = 32'h100 + 32'(4 * i);
            tick();
            if (i == 7) check("trc no drop at 8", 64'(b32.trc_drop_o), 64'd0);
            if (i == 8) check("trc drop at 9",    64'(b32.trc_drop_o), 64'd1);
        end
        drive(7'b0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("trc vld %0d", k), 64'(b32.trc_vld_o), 64'd1);
            check($sformatf("trc pc %0d", k),  64'(b32.trc_pc_o), 64'(32'h100 + 32'(4 * k)));
            b32.trc_pop_i = 1'b1; tick(); b32.trc_pop_i = 1'b0;
        end
        check("trc empty", 64'(b32.trc_vld_o), 64'd0);
        b32.trc_pop_i = 1'b1; tick(); b32.trc_pop_i = 1'b0;
        check("trc pop empty vld", 64'(b32.trc_vld_o), 64'd0);
        check("trc pop empty pc",  64'(b32.trc_pc_o), 64'd0);
        check("trc drop sticky",   64'(b32.trc_drop_o), 64'd1);
        drive(7'b0010000); tick(); drive(7'b0);
        check("trc drop clr", 64'(b32.trc_drop_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            drive(7'b0001100);
            b32.pc_i = 32'h200 + 32'(4 * i);
            tick();
        end
        b32.pc_i = 32'h300; b32.trc_pop_i = 1'b1; tick(); b32.trc_pop_i = 1'b0;
        drive(7'b0);
        check("trc full push+pop drop", 64'(b32.trc_drop_o), 64'd0);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("trc2 pc %0d", k), 64'(b32.trc_pc_o), 64'(32'h204 + 32'(4 * k)));
            b32.trc_pop_i = 1'b1; tick(); b32.trc_pop_i = 1'b0;
        end
        check("trc2 last pc", 64'(b32.trc_pc_o), 64'h300);
`else
        drive(7'b0001100);
        b32.pc_i = 32'h100; b32.trc_pop_i = 1'b1;
        tick();
        drive(7'b0); b32.trc_pop_i = 1'b0;
        check("trc off vld",  64'(b32.trc_vld_o), 64'd0);
        check("trc off pc",   64'(b32.trc_pc_o), 64'd0);
        check("trc off drop", 64'(b32.trc_drop_o), 64'd0);
`endif

        // 4-bit counters: saturation at 15 and sticky overflow.
        b4.start_i = 1'b1; tick(); b4.start_i = 1'b0;
        b4.insn_vld_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            b4.snap_req_i = (i == 20);
            tick();
            if (i == 15) check("c4 ovf at 15", 64'(b4.ovf_o), 64'd0);
            if (i == 16) check("c4 ovf at 16", 64'(b4.ovf_o), 64'd1);
        end
        b4.snap_req_i = 1'b0; b4.insn_vld_i = 1'b0;
        check("c4 snap_vld", 64'(b4.snap_vld_o), 64'd1);
        check("c4 sat cyc",  64'(b4.cyc_cnt_o), 64'd15);
        check("c4 sat insn", 64'(b4.insn_cnt_o), 64'd15);
        b4.stop_i = 1'b1; tick(); b4.stop_i = 1'b0;
        check("c4 hold run",  64'(b4.run_o), 64'd0);
        check("c4 ovf kept",  64'(b4.ovf_o), 64'd1);
        b4.clr_i = 1'b1; tick(); b4.clr_i = 1'b0;
        check("c4 ovf clr",       64'(b4.ovf_o), 64'd0);
        check("c4 snap kept clr", 64'(b4.cyc_cnt_o), 64'd15);
        b4.snap_req_i = 1'b1; tick(); b4.snap_req_i = 1'b0;
        check("c4 clr snap_vld", 64'(b4.snap_vld_o), 64'd1);
        check("c4 clr cyc",      64'(b4.cyc_cnt_o), 64'd0);
        check("c4 clr insn",     64'(b4.insn_cnt_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
